motor_ramp_ctrl: RTL and testbench
==================================

Name: motor_ramp_ctrl

Overview:
Slew-limited two-motor drive controller, successor to the fixed-table motor driver. Accepts per-wheel target duty and direction commands through a valid/ready handshake. Ramps each wheel's duty toward its target at a programmable rate and forces a ramp-to-zero plus coast dead time before any direction reversal. Outputs feed the existing motor_pwm generators (duty) and the H-bridge IN pins.

Parameters:
DUTY_W, 10, width of duty values
MAX_DUTY, 1023, saturation limit applied to accepted targets
RAMP_DIV, 100000, clk cycles per ramp tick (>=2)
RAMP_STEP, 8, max duty change per tick (>=1)
DEAD_TICKS, 4, ticks of coast at zero duty before a reversal (>=1)

Ports:
clk  in  1  system clock, 100 MHz
rst  in  1  synchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  controller can accept a command
cmd_l_duty  in  DUTY_W  left target duty
cmd_l_dir  in  1  left target direction, 0=fwd, 1=rev
cmd_r_duty  in  DUTY_W  right target duty
cmd_r_dir  in  1  right target direction
estop  in  1  level emergency stop
l_duty  out  DUTY_W  left duty to motor_pwm
r_duty  out  DUTY_W  right duty to motor_pwm
l_IN  out  2  left bridge: 10=fwd, 01=rev, 00=coast
r_IN  out  2  right bridge, same encoding
settled  out  1  both wheels at target duty/dir in RUN

Behaviour:
- Reset (sync, on clk edge with rst=1): duties 0, l_IN=r_IN=2'b10, targets 0/fwd, both FSMs RUN, tick counter 0, settled=1, cmd_ready=0 during rst.
- Tick: counter 0..RAMP_DIV-1; tick is a 1-cycle pulse when counter==RAMP_DIV-1, then counter wraps to 0. Counter free-runs and is not reset by commands.
- Handshake: cmd_ready = !rst && !estop. Accept on valid&&ready edge; each target duty registered as min(cmd_duty, MAX_DUTY). Target dir registered directly. New command overwrites targets at any FSM state. First duty change occurs on the next tick after acceptance, never in the accept cycle.
- Per-wheel FSM (identical, independent):
  - RUN: IN = cur_dir encoding.
    - If tgt_dir==cur_dir: on tick, cur moves toward tgt by min(RAMP_STEP, |tgt-cur|); no overshoot.
    - If tgt_dir!=cur_dir and cur>0: go BRAKE.
    - If tgt_dir!=cur_dir and cur==0: go DEAD.
  - BRAKE: on tick, cur -= min(RAMP_STEP, cur); IN stays cur_dir. When cur reaches 0, go DEAD next cycle, dead counter cleared. If tgt_dir returns to cur_dir, go RUN (ramp continues from present cur).
  - DEAD: duty 0, IN=2'b00. Dead counter increments per tick. When counter reaches DEAD_TICKS, cur_dir <= tgt_dir and go RUN. If tgt_dir becomes equal to cur_dir, go RUN next cycle without toggling dir.
- Duty arithmetic unsigned DUTY_W; comparisons done before subtract, so no wrap below 0 or above MAX_DUTY.
- estop (level, highest priority after rst): next edge duties 0, targets 0 with dirs kept, FSMs RUN, IN=cur_dir encoding (bridge braking via zero PWM). Commands refused while high. Release resumes normal operation with targets 0.
- Simultaneous accept and tick in one cycle: tick steps toward the OLD target; new target applies from the following tick.
- settled = both wheels in RUN && cur==tgt && cur_dir==tgt_dir; registered, updates one cycle after the condition.

Test Plan:
Bench parameters are RAMP_DIV=4, RAMP_STEP=8, DEAD_TICKS=2, MAX_DUTY=900.
- Ramp up: from reset, cmd L=100 fwd, R=100 fwd -> each tick duty 8,16,...,96,100 (13 ticks); IN=10 throughout; settled rises the cycle after 100.
- Reversal: settled L=40 fwd, cmd L=24 rev -> 32,24,16,8,0 with IN=10. Then IN=00 for 2 ticks. Then IN=01 and 8,16,24; R unaffected.
- Clamp and no overshoot: cmd L=1023 -> target 900, final duty 900. Then cmd L=895 -> single step 900->895.
- Retarget in DEAD: during coast, re-command fwd 16 -> IN=10 next cycle, ramp 8,16, no rev phase.
- estop mid-ramp at duty 48 -> both duties 0 next edge, cmd_ready=0; cmd_valid ignored. After release, duties stay 0 until a new command is accepted.
- Reset mid-BRAKE: assert rst for 1 cycle -> duties 0, IN=10, settled=1, no DEAD phase afterwards.

Source files
------------

// File: rtl/motor_ramp_if.sv
// Command channel into motor_ramp_ctrl: per-wheel target duty and direction
// qualified by a valid/ready handshake.
interface motor_ramp_if #(
  parameter int DUTY_W = 10
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [DUTY_W-1:0] cmd_l_duty;
  logic              cmd_l_dir;
  logic [DUTY_W-1:0] cmd_r_duty;
  logic              cmd_r_dir;

  modport master (
    output cmd_valid, cmd_l_duty, cmd_l_dir, cmd_r_duty, cmd_r_dir,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_l_duty, cmd_l_dir, cmd_r_duty, cmd_r_dir,
    output cmd_ready
  );
endinterface

// File: rtl/motor_ramp_ctrl.sv
// Slew-limited two-wheel drive controller: ramps duty toward target each tick and
// brakes to zero plus a coast dead time before any direction reversal.
//
//   state | meaning
//   RUN   | bridge driven in cur_dir, duty ramps toward target
//   BRAKE | target dir differs, duty ramps down to zero, bridge still in cur_dir
//   DEAD  | duty 0, bridge coasting (00) for DEAD_TICKS ticks before reversal
module motor_ramp_ctrl #(
  parameter int DUTY_W     = 10,
  parameter int MAX_DUTY   = 1023,
  parameter int RAMP_DIV   = 100000,
  parameter int RAMP_STEP  = 8,
  parameter int DEAD_TICKS = 4
) (
  input  logic              clk,
  input  logic              rst,
  motor_ramp_if.slave       cmd,
  input  logic              estop,
  output logic [DUTY_W-1:0] l_duty,
  output logic [DUTY_W-1:0] r_duty,
  output logic [1:0]        l_IN,
  output logic [1:0]        r_IN,
  output logic              settled
);

  localparam int CW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int DW = $clog2(DEAD_TICKS + 1);
  localparam logic [CW-1:0]     DIV_LAST = CW'(RAMP_DIV - 1);
  localparam logic [DW-1:0]     DEAD_END = DW'(DEAD_TICKS);
  localparam logic [DUTY_W-1:0] STEP     = DUTY_W'(RAMP_STEP);
  localparam logic [DUTY_W-1:0] DUTY_MAX = DUTY_W'(MAX_DUTY);

  typedef enum logic [1:0] {RUN, BRAKE, DEAD} state_t;

  state_t            st_q   [2];
  state_t            st_d   [2];
  logic [DUTY_W-1:0] cur_q  [2];
  logic [DUTY_W-1:0] cur_d  [2];
  logic [DUTY_W-1:0] tgt_q  [2];
  logic [DUTY_W-1:0] tgt_d  [2];
  logic [DW-1:0]     dcnt_q [2];
  logic [DW-1:0]     dcnt_d [2];
  logic [1:0]        dir_q, dir_d, tdir_q, tdir_d;
  logic [1:0]        in_enc [2];
  logic [DUTY_W-1:0] cmd_duty [2];
  logic [1:0]        cmd_dir;
  logic [CW-1:0]     div_q;
  logic              tick, accept, settled_d;

  assign tick          = (div_q == DIV_LAST);
  assign cmd.cmd_ready = !rst && !estop;
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;
  assign cmd_duty[0]   = cmd.cmd_l_duty;
  assign cmd_duty[1]   = cmd.cmd_r_duty;
  assign cmd_dir       = {cmd.cmd_r_dir, cmd.cmd_l_dir};

  // Moves at most STEP toward tgt; the difference is formed before any
  // subtraction from cur, so the result never wraps or overshoots.
  function automatic logic [DUTY_W-1:0] step_toward(input logic [DUTY_W-1:0] cur,
                                                    input logic [DUTY_W-1:0] tgt);
    logic [DUTY_W-1:0] diff;
    if (cur < tgt) begin
      diff = tgt - cur;
      return cur + ((diff > STEP) ? STEP : diff);
    end else begin
      diff = cur - tgt;
      return cur - ((diff > STEP) ? STEP : diff);
    end
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q   <= '0;
      settled <= 1'b1;
      dir_q   <= '0;
      tdir_q  <= '0;
      for (int w = 0; w < 2; w++) begin
        st_q[w]   <= RUN;
        cur_q[w]  <= '0;
        tgt_q[w]  <= '0;
        dcnt_q[w] <= '0;
      end
    end else begin
      div_q   <= tick ? '0 : div_q + CW'(1);
      settled <= settled_d;
      dir_q   <= dir_d;
      tdir_q  <= tdir_d;
      for (int w = 0; w < 2; w++) begin
        st_q[w]   <= st_d[w];
        cur_q[w]  <= cur_d[w];
        tgt_q[w]  <= tgt_d[w];
        dcnt_q[w] <= dcnt_d[w];
      end
    end
  end

  // Transitions use the registered target, so a tick coinciding with an
  // accept still steps toward the previous target.
  always_comb begin
    settled_d = 1'b1;
    dir_d     = dir_q;
    tdir_d    = tdir_q;
    for (int w = 0; w < 2; w++) begin
      st_d[w]   = st_q[w];
      cur_d[w]  = cur_q[w];
      tgt_d[w]  = tgt_q[w];
      dcnt_d[w] = dcnt_q[w];
      if (estop) begin
        st_d[w]   = RUN;
        cur_d[w]  = '0;
        tgt_d[w]  = '0;
        dcnt_d[w] = '0;
      end else begin
        if (accept) begin
          tgt_d[w]  = (cmd_duty[w] > DUTY_MAX) ? DUTY_MAX : cmd_duty[w];
          tdir_d[w] = cmd_dir[w];
        end
        case (st_q[w])
          RUN: begin
            if (tdir_q[w] == dir_q[w]) begin
              if (tick) cur_d[w] = step_toward(cur_q[w], tgt_q[w]);
            end else if (cur_q[w] != '0) begin
              st_d[w] = BRAKE;
            end else begin
              st_d[w]   = DEAD;
              dcnt_d[w] = '0;
            end
          end
          BRAKE: begin
            if (tdir_q[w] == dir_q[w]) begin
              st_d[w] = RUN;
            end else if (cur_q[w] == '0) begin
              st_d[w]   = DEAD;
              dcnt_d[w] = '0;
            end else if (tick) begin
              cur_d[w] = step_toward(cur_q[w], '0);
            end
          end
          DEAD: begin
            if (tdir_q[w] == dir_q[w]) begin
              st_d[w] = RUN;
            end else if (dcnt_q[w] == DEAD_END) begin
              st_d[w]  = RUN;
              dir_d[w] = tdir_q[w];
            end else if (tick) begin
              dcnt_d[w] = dcnt_q[w] + DW'(1);
            end
          end
          default: st_d[w] = RUN;
        endcase
      end
      settled_d = settled_d && (st_q[w] == RUN) && (cur_q[w] == tgt_q[w]) &&
                  (dir_q[w] == tdir_q[w]);
    end
  end

  always_comb begin
    for (int w = 0; w < 2; w++) begin
      if (st_q[w] == DEAD) in_enc[w] = 2'b00;
      else                 in_enc[w] = dir_q[w] ? 2'b01 : 2'b10;
    end
  end

  assign l_duty = cur_q[0];
  assign r_duty = cur_q[1];
  assign l_IN   = in_enc[0];
  assign r_IN   = in_enc[1];

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Directed bench for motor_ramp_ctrl with short ramp tick and dead time.
module tb_motor_ramp_ctrl;

  localparam int DUTY_W = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              estop = 1'b0;
  logic [DUTY_W-1:0] l_duty, r_duty;
  logic [1:0]        l_in, r_in;
  logic              settled;
  int                n_chk = 0;
  int                n_fail = 0;
  int                ref_div = 0;
  bit                last_edge_tick = 1'b0;

  motor_ramp_if #(.DUTY_W(DUTY_W)) cmd_if ();

  motor_ramp_ctrl #(
    .DUTY_W(DUTY_W), .MAX_DUTY(900), .RAMP_DIV(4), .RAMP_STEP(8), .DEAD_TICKS(2)
  ) dut (
    .clk(clk), .rst(rst), .cmd(cmd_if), .estop(estop),
    .l_duty(l_duty), .r_duty(r_duty), .l_IN(l_in), .r_IN(r_in), .settled(settled)
  );

  always #5 clk = ~clk;

  // Independent model of the ramp tick: period 4 cycles, held at 0 in reset.
  always @(posedge clk) begin
    last_edge_tick <= !rst && (ref_div == 3);
    if (rst || ref_div == 3) ref_div <= 0;
    else                     ref_div <= ref_div + 1;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tick();
    do step(); while (!last_edge_tick);
  endtask

  task automatic send(input int ld, input bit ldir, input int rd, input bit rdir);
    cmd_if.cmd_l_duty = DUTY_W'(ld);
    cmd_if.cmd_l_dir  = ldir;
    cmd_if.cmd_r_duty = DUTY_W'(rd);
    cmd_if.cmd_r_dir  = rdir;
    cmd_if.cmd_valid  = 1'b1;
    step();
    cmd_if.cmd_valid  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cmd_if.cmd_valid  = 1'b0;
    cmd_if.cmd_l_duty = '0;
    cmd_if.cmd_l_dir  = 1'b0;
    cmd_if.cmd_r_duty = '0;
    cmd_if.cmd_r_dir  = 1'b0;
    repeat (3) step();
    check_eq("rst_ready", cmd_if.cmd_ready, 0);
    check_eq("rst_lduty", l_duty, 0);
    check_eq("rst_rduty", r_duty, 0);
    check_eq("rst_lin", l_in, 2);
    check_eq("rst_rin", r_in, 2);
    check_eq("rst_settled", settled, 1);
    rst = 1'b0;
    #1;
    check_eq("ready_after_rst", cmd_if.cmd_ready, 1);

    // ramp up both wheels to 100 fwd
    wait_tick();
    send(100, 0, 100, 0);
    check_eq("accept_no_step", l_duty, 0);
    for (int i = 1; i <= 13; i++) begin
      wait_tick();
      check_eq("ramp_l", l_duty, (8 * i > 100) ? 100 : 8 * i);
      check_eq("ramp_r", r_duty, (8 * i > 100) ? 100 : 8 * i);
      check_eq("ramp_lin", l_in, 2);
    end
    check_eq("settled_lag", settled, 0);
    step();
    check_eq("settled_up", settled, 1);

    // down to 40 fwd, then reverse to 24 rev
    wait_tick();
    send(40, 0, 100, 0);
    repeat (8) wait_tick();
    check_eq("l_at_40", l_duty, 40);
    step();
    check_eq("settled_40", settled, 1);
    wait_tick();
    send(24, 1, 100, 0);
    for (int i = 1; i <= 5; i++) begin
      wait_tick();
      check_eq("brake_l", l_duty, 40 - 8 * i);
      check_eq("brake_lin", l_in, 2);
      check_eq("brake_r", r_duty, 100);
    end
    step();
    check_eq("dead_lin0", l_in, 0);
    wait_tick();
    check_eq("dead_lin1", l_in, 0);
    check_eq("dead_lduty", l_duty, 0);
    wait_tick();
    check_eq("dead_lin2", l_in, 0);
    step();
    check_eq("rev_lin", l_in, 1);
    for (int i = 1; i <= 3; i++) begin
      wait_tick();
      check_eq("rev_l", l_duty, 8 * i);
      check_eq("rev_lin_ramp", l_in, 1);
      check_eq("rev_rin", r_in, 2);
    end
    step();
    check_eq("rev_settled", settled, 1);

    // clamp 1023 -> 900, then single step down to 895
    wait_tick();
    send(1023, 1, 100, 0);
    repeat (109) wait_tick();
    check_eq("clamp_896", l_duty, 896);
    wait_tick();
    check_eq("clamp_900", l_duty, 900);
    wait_tick();
    check_eq("clamp_hold", l_duty, 900);
    send(895, 1, 100, 0);
    wait_tick();
    check_eq("step_895", l_duty, 895);
    wait_tick();
    check_eq("hold_895", l_duty, 895);

    // estop clears duties, keeps direction
    estop = 1'b1;
    #1;
    check_eq("estop_ready", cmd_if.cmd_ready, 0);
    step();
    check_eq("estop_l", l_duty, 0);
    check_eq("estop_r", r_duty, 0);
    check_eq("estop_lin", l_in, 1);
    check_eq("estop_rin", r_in, 2);
    estop = 1'b0;
    step();

    // estop mid-ramp at 48 with a command pending
    wait_tick();
    send(100, 1, 100, 0);
    repeat (6) wait_tick();
    check_eq("pre_estop_l", l_duty, 48);
    check_eq("pre_estop_r", r_duty, 48);
    estop = 1'b1;
    cmd_if.cmd_l_duty = 10'd300;
    cmd_if.cmd_r_duty = 10'd300;
    cmd_if.cmd_valid  = 1'b1;
    #1;
    check_eq("estop2_ready", cmd_if.cmd_ready, 0);
    step();
    check_eq("estop2_l", l_duty, 0);
    check_eq("estop2_r", r_duty, 0);
    repeat (2) wait_tick();
    check_eq("estop2_hold_l", l_duty, 0);
    cmd_if.cmd_valid = 1'b0;
    step();
    estop = 1'b0;
    repeat (3) wait_tick();
    check_eq("release_l", l_duty, 0);
    check_eq("release_r", r_duty, 0);
    check_eq("release_lin", l_in, 1);
    check_eq("release_settled", settled, 1);

    // bring left to fwd at zero duty, then retarget during the coast
    wait_tick();
    send(0, 0, 0, 0);
    repeat (4) wait_tick();
    check_eq("fwd_zero_lin", l_in, 2);
    wait_tick();
    send(0, 1, 0, 0);
    step();
    check_eq("coast_lin", l_in, 0);
    send(16, 0, 0, 0);
    check_eq("coast_accept_lin", l_in, 0);
    step();
    check_eq("retgt_lin", l_in, 2);
    check_eq("retgt_l0", l_duty, 0);
    wait_tick();
    check_eq("retgt_l8", l_duty, 8);
    wait_tick();
    check_eq("retgt_l16", l_duty, 16);
    check_eq("retgt_lin16", l_in, 2);
    wait_tick();
    check_eq("retgt_hold", l_duty, 16);
    check_eq("retgt_no_rev", l_in, 2);

    // reset while braking
    wait_tick();
    send(16, 1, 0, 0);
    step();
    check_eq("brake_pre_rst", l_in, 2);
    rst = 1'b1;
    #1;
    check_eq("rst2_ready", cmd_if.cmd_ready, 0);
    step();
    check_eq("rst2_l", l_duty, 0);
    check_eq("rst2_lin", l_in, 2);
    check_eq("rst2_settled", settled, 1);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_tick();
      check_eq("post_rst_lin", l_in, 2);
      check_eq("post_rst_l", l_duty, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
